// File: rtl/layer_sched.sv
// Output-layer sequencer: issues one engine request per neuron, tracks the signed argmax, reports winner.
// Latency N_NEURON*(L+2)+1 cycles from start sample; start is ignored while busy, abort returns to IDLE.
module layer_sched #(
  parameter int N_NEURON = 10,
  parameter int TIMEOUT  = 511
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        abort_i,
  output logic        neu_go_o,
  output logic [3:0]  neu_sel_o,
  input  logic        neu_done_i,
  input  logic [25:0] neu_out_i,
  output logic        busy_o,
  output logic        class_valid_o,
  output logic [3:0]  class_out_o,
  output logic [25:0] max_val_o,
  output logic        err_o
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CMP, S_DONE, S_ERR} state_t;

  localparam logic [3:0] LAST_IDX = 4'(N_NEURON - 1);
  localparam logic [9:0] TMO      = 10'(TIMEOUT);

  state_t      state_q;
  logic [3:0]  idx_q;
  logic [9:0]  timer_q;
  logic [25:0] cur_q;
  logic [25:0] best_q;
  logic [3:0]  best_idx_q;
  logic        neu_go_q;
  logic [3:0]  neu_sel_q;
  logic        busy_q;
  logic        class_valid_q;
  logic [3:0]  class_out_q;
  logic [25:0] max_val_q;
  logic        err_q;

  logic [25:0] best_d;
  logic [3:0]  best_idx_d;

  // Strict greater-than keeps the lower index on ties; neuron 0 always seeds the running best.
  always_comb begin
    best_d     = best_q;
    best_idx_d = best_idx_q;
    if (idx_q == 4'd0 || $signed(cur_q) > $signed(best_q)) begin
      best_d     = cur_q;
      best_idx_d = idx_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      timer_q       <= '0;
      cur_q         <= '0;
      best_q        <= '0;
      best_idx_q    <= '0;
      neu_go_q      <= 1'b0;
      neu_sel_q     <= '0;
      busy_q        <= 1'b0;
      class_valid_q <= 1'b0;
      class_out_q   <= '0;
      max_val_q     <= '0;
      err_q         <= 1'b0;
    end else begin
      neu_go_q      <= 1'b0;
      class_valid_q <= 1'b0;
      err_q         <= 1'b0;
      if (abort_i) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_i) begin
              idx_q     <= '0;
              neu_sel_q <= '0;
              neu_go_q  <= 1'b1;
              busy_q    <= 1'b1;
              state_q   <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            timer_q <= '0;
            state_q <= S_WAIT;
          end
          S_WAIT: begin
            if (neu_done_i) begin
              cur_q   <= neu_out_i;
              state_q <= S_CMP;
            end else if (timer_q == TMO) begin
              err_q   <= 1'b1;
              state_q <= S_ERR;
            end else begin
              timer_q <= timer_q + 10'd1;
            end
          end
          S_CMP: begin
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            // Results are loaded on entry to DONE so they line up with the class_valid pulse.
            if (idx_q == LAST_IDX) begin
              class_out_q   <= best_idx_d;
              max_val_q     <= best_d;
              class_valid_q <= 1'b1;
              state_q       <= S_DONE;
            end else begin
              idx_q     <= idx_q + 4'd1;
              neu_sel_q <= idx_q + 4'd1;
              neu_go_q  <= 1'b1;
              state_q   <= S_ISSUE;
            end
          end
          S_DONE, S_ERR: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign neu_go_o      = neu_go_q;
  assign neu_sel_o     = neu_sel_q;
  assign busy_o        = busy_q;
  assign class_valid_o = class_valid_q;
  assign class_out_o   = class_out_q;
  assign max_val_o     = max_val_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_layer_sched.sv
// Directed bench for layer_sched with a fixed-latency engine model (L=4) answering from a value table.
module tb_layer_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        neu_go;
  logic [3:0]  neu_sel;
  logic        neu_done;
  logic        eng_done;
  logic        stray_done;
  logic [25:0] neu_out;
  logic        busy;
  logic        class_valid;
  logic [3:0]  class_out;
  logic [25:0] max_val;
  logic        err;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  assign neu_done = eng_done | stray_done;

  layer_sched dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .abort_i      (abort),
    .neu_go_o     (neu_go),
    .neu_sel_o    (neu_sel),
    .neu_done_i   (neu_done),
    .neu_out_i    (neu_out),
    .busy_o       (busy),
    .class_valid_o(class_valid),
    .class_out_o  (class_out),
    .max_val_o    (max_val),
    .err_o        (err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: answers neu_go after L cycles with tbl[sel], except for the neuron in skip_idx.
  logic [25:0] tbl [10];
  int          skip_idx = 15;
  int          eng_cnt = 0;
  bit          eng_act = 0;
  logic [3:0]  eng_sel = '0;
  initial begin
    eng_done = 1'b0;
    neu_out  = '0;
  end
  always @(negedge clk) begin
    eng_done = 1'b0;
    if (rst) begin
      eng_act = 0;
    end else begin
      if (eng_act) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          eng_act = 0;
          if (int'(eng_sel) != skip_idx) begin
            eng_done = 1'b1;
            neu_out  = tbl[eng_sel];
          end
        end
      end
      if (neu_go) begin
        eng_act = 1;
        eng_cnt = 4;
        eng_sel = neu_sel;
      end
    end
  end

  // Output monitor
  int         go_cnt = 0, cv_cnt = 0, err_cnt = 0, cv_cyc = 0, err_cyc = 0;
  logic [3:0] sel_log [64];
  always @(negedge clk) begin
    if (neu_go) begin
      sel_log[go_cnt % 64] = neu_sel;
      go_cnt++;
    end
    if (class_valid) begin
      cv_cnt++;
      cv_cyc = cyc;
    end
    if (err) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  task automatic load_a();
    int v[10];
    v = '{5, -3, 100, 7, 100, 0, -50, 2, 99, 1};
    for (int i = 0; i < 10; i++) tbl[i] = 26'(v[i]);
  endtask

  task automatic load_neg();
    int v[10];
    v = '{-9, -2, -8, -7, -6, -5, -4, -3, -10, -11};
    for (int i = 0; i < 10; i++) tbl[i] = 26'(v[i]);
  endtask

  task automatic pulse_start(output int s0);
    @(negedge clk);
    start = 1'b1;
    s0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_evt(input int cv_base, input int err_base, input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      #1;
      if (cv_cnt > cv_base || err_cnt > err_base) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; stray_done = 1'b0;
    repeat (3) @(negedge clk);
    nvec++; if (neu_go !== 1'b0)       begin nerr++; $display("FAIL reset_neu_go got=%b exp=0", neu_go); end
    nvec++; if (neu_sel !== 4'd0)      begin nerr++; $display("FAIL reset_neu_sel got=%0d exp=0", neu_sel); end
    nvec++; if (busy !== 1'b0)         begin nerr++; $display("FAIL reset_busy got=%b exp=0", busy); end
    nvec++; if (class_valid !== 1'b0)  begin nerr++; $display("FAIL reset_class_valid got=%b exp=0", class_valid); end
    nvec++; if (class_out !== 4'd0)    begin nerr++; $display("FAIL reset_class_out got=%0d exp=0", class_out); end
    nvec++; if (max_val !== 26'd0)     begin nerr++; $display("FAIL reset_max_val got=%h exp=0", max_val); end
    nvec++; if (err !== 1'b0)          begin nerr++; $display("FAIL reset_err got=%b exp=0", err); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_argmax();
    int s0, g0, c0, e0, bad;
    bit ok;
    load_a();
    g0 = go_cnt; c0 = cv_cnt; e0 = err_cnt;
    pulse_start(s0);
    wait_evt(c0, e0, 200, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL argmax_done got=timeout exp=class_valid"); end
    nvec++; if (cv_cyc - s0 != 61) begin nerr++; $display("FAIL argmax_latency got=%0d exp=61", cv_cyc - s0); end
    nvec++; if (class_out !== 4'd2) begin nerr++; $display("FAIL argmax_class_out got=%0d exp=2", class_out); end
    nvec++; if (max_val !== 26'd100) begin nerr++; $display("FAIL argmax_max_val got=%h exp=%h", max_val, 26'd100); end
    nvec++; if (go_cnt - g0 != 10) begin nerr++; $display("FAIL argmax_go_count got=%0d exp=10", go_cnt - g0); end
    bad = 0;
    for (int k = 0; k < 10; k++) if (sel_log[(g0 + k) % 64] !== 4'(k)) bad++;
    nvec++; if (bad != 0) begin nerr++; $display("FAIL argmax_sel_order got=%0d wrong exp=0 wrong", bad); end
    @(negedge clk);
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL argmax_busy_after got=%b exp=0", busy); end
    nvec++; if (cv_cnt - c0 != 1) begin nerr++; $display("FAIL argmax_cv_pulses got=%0d exp=1", cv_cnt - c0); end
  endtask

  task automatic test_back_to_back();
    int s0, s1, c0, e0, c1;
    bit ok;
    load_a();
    c0 = cv_cnt; e0 = err_cnt;
    pulse_start(s0);
    wait_evt(c0, e0, 200, ok);
    load_neg();
    c1 = cv_cnt;
    @(negedge clk);
    start = 1'b1;
    s1 = cyc;
    @(negedge clk);
    start = 1'b0;
    wait_evt(c1, e0, 200, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL b2b_done got=timeout exp=class_valid"); end
    nvec++; if (cv_cyc - s1 != 61) begin nerr++; $display("FAIL b2b_latency got=%0d exp=61", cv_cyc - s1); end
    nvec++; if (class_out !== 4'd1) begin nerr++; $display("FAIL neg_class_out got=%0d exp=1", class_out); end
    nvec++; if (max_val !== 26'h3FFFFFE) begin nerr++; $display("FAIL neg_max_val got=%h exp=3fffffe", max_val); end
    nvec++; if (cv_cnt - c0 != 2) begin nerr++; $display("FAIL b2b_cv_pulses got=%0d exp=2", cv_cnt - c0); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int s0, g0, c0, e0;
    bit ok;
    load_a();
    skip_idx = 3;
    g0 = go_cnt; c0 = cv_cnt; e0 = err_cnt;
    pulse_start(s0);
    wait_evt(c0, e0, 700, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL tmo_event got=none exp=err"); end
    nvec++; if (err_cnt - e0 != 1) begin nerr++; $display("FAIL tmo_err_pulses got=%0d exp=1", err_cnt - e0); end
    nvec++; if (err_cyc - s0 != 532) begin nerr++; $display("FAIL tmo_err_cycle got=%0d exp=532", err_cyc - s0); end
    nvec++; if (cv_cnt != c0) begin nerr++; $display("FAIL tmo_class_valid got=%0d exp=0", cv_cnt - c0); end
    nvec++; if (go_cnt - g0 != 4) begin nerr++; $display("FAIL tmo_go_count got=%0d exp=4", go_cnt - g0); end
    @(negedge clk);
    #1;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL tmo_busy_after got=%b exp=0", busy); end
    nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL tmo_err_width got=%b exp=0", err); end
    nvec++; if (class_out !== 4'd1) begin nerr++; $display("FAIL tmo_class_out_held got=%0d exp=1", class_out); end
    nvec++; if (max_val !== 26'h3FFFFFE) begin nerr++; $display("FAIL tmo_max_val_held got=%h exp=3fffffe", max_val); end
    skip_idx = 15;
  endtask

  task automatic test_start_busy();
    int s0, g0, c0, e0;
    bit ok;
    load_a();
    g0 = go_cnt; c0 = cv_cnt; e0 = err_cnt;
    pulse_start(s0);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_evt(c0, e0, 200, ok);
    repeat (2) @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    nvec++; if (cv_cnt - c0 != 1) begin nerr++; $display("FAIL busy_cv_pulses got=%0d exp=1", cv_cnt - c0); end
    nvec++; if (go_cnt - g0 != 10) begin nerr++; $display("FAIL busy_go_count got=%0d exp=10", go_cnt - g0); end
    nvec++; if (cv_cyc - s0 != 61) begin nerr++; $display("FAIL busy_latency got=%0d exp=61", cv_cyc - s0); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL stray_busy got=%b exp=0", busy); end
    nvec++; if (class_out !== 4'd2) begin nerr++; $display("FAIL busy_class_out got=%0d exp=2", class_out); end
    nvec++; if (err_cnt != e0) begin nerr++; $display("FAIL busy_err got=%0d exp=0", err_cnt - e0); end
  endtask

  task automatic test_abort();
    int s0, g0, c0, e0, g1, bad;
    bit ok, seen;
    load_a();
    g0 = go_cnt; c0 = cv_cnt; e0 = err_cnt;
    pulse_start(s0);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (go_cnt - g0 >= 6) begin seen = 1; break; end
      @(negedge clk);
      #1;
    end
    nvec++; if (!seen) begin nerr++; $display("FAIL abort_reach_n5 got=timeout exp=neu_go"); end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL abort_busy got=%b exp=0", busy); end
    repeat (10) @(negedge clk);
    #1;
    nvec++; if (cv_cnt != c0) begin nerr++; $display("FAIL abort_class_valid got=%0d exp=0", cv_cnt - c0); end
    nvec++; if (err_cnt != e0) begin nerr++; $display("FAIL abort_err got=%0d exp=0", err_cnt - e0); end
    nvec++; if (go_cnt - g0 != 6) begin nerr++; $display("FAIL abort_go_count got=%0d exp=6", go_cnt - g0); end
    nvec++; if (class_out !== 4'd2) begin nerr++; $display("FAIL abort_class_out_held got=%0d exp=2", class_out); end
    g1 = go_cnt;
    pulse_start(s0);
    wait_evt(c0, e0, 200, ok);
    nvec++; if (!ok || cv_cnt - c0 != 1) begin nerr++; $display("FAIL abort_restart got=%0d pulses exp=1", cv_cnt - c0); end
    bad = 0;
    for (int k = 0; k < 10; k++) if (sel_log[(g1 + k) % 64] !== 4'(k)) bad++;
    nvec++; if (bad != 0 || go_cnt - g1 != 10) begin nerr++; $display("FAIL abort_restart_sel got=%0d wrong exp=0 wrong", bad); end
    nvec++; if (max_val !== 26'd100) begin nerr++; $display("FAIL abort_restart_max got=%h exp=%h", max_val, 26'd100); end
    @(negedge clk);
  endtask

  task automatic test_reset_cmp();
    int s0, g0, c0, e0;
    load_a();
    pulse_start(s0);
    repeat (17) @(negedge clk);
    nvec++; if (busy !== 1'b1 || neu_sel !== 4'd2) begin nerr++; $display("FAIL rstcmp_pre got=busy%b sel%0d exp=busy1 sel2", busy, neu_sel); end
    rst = 1'b1;
    #1;
    nvec++; if (busy !== 1'b0)        begin nerr++; $display("FAIL rstcmp_busy got=%b exp=0", busy); end
    nvec++; if (neu_sel !== 4'd0)     begin nerr++; $display("FAIL rstcmp_neu_sel got=%0d exp=0", neu_sel); end
    nvec++; if (class_out !== 4'd0)   begin nerr++; $display("FAIL rstcmp_class_out got=%0d exp=0", class_out); end
    nvec++; if (max_val !== 26'd0)    begin nerr++; $display("FAIL rstcmp_max_val got=%h exp=0", max_val); end
    nvec++; if (neu_go !== 1'b0 || class_valid !== 1'b0 || err !== 1'b0) begin
      nerr++; $display("FAIL rstcmp_pulses got=%b%b%b exp=000", neu_go, class_valid, err);
    end
    @(negedge clk);
    rst = 1'b0;
    g0 = go_cnt; c0 = cv_cnt; e0 = err_cnt;
    repeat (30) @(negedge clk);
    #1;
    nvec++; if (go_cnt != g0 || cv_cnt != c0 || err_cnt != e0) begin
      nerr++; $display("FAIL rstcmp_quiet got=go%0d cv%0d err%0d exp=0 0 0", go_cnt - g0, cv_cnt - c0, err_cnt - e0);
    end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rstcmp_busy_after got=%b exp=0", busy); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=no_finish exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_argmax();
    test_back_to_back();
    test_timeout();
    test_start_busy();
    test_abort();
    test_reset_cmp();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
